sync_fifo_gen2: RTL and testbench
=================================

SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of entries; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning the occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have a single clock and an asynchronous, active-high reset, with the ports below (clock and reset first):
- clk  input  1  clock; all sequential logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- w_en  input  1  write request
- r_en  input  1  read request
- data_in  input  WIDTH  write data
- data_out  output  WIDTH  read data
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- almost_full  output  1  occupancy >= AF_LEVEL
- almost_empty  output  1  occupancy <= AE_LEVEL
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  one-cycle pulse: a write was rejected
- underflow  output  1  one-cycle pulse: a read was rejected

Function
REQ-006 A write SHALL be accepted iff w_en=1 and full=0; data_in is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-007 A read SHALL be accepted iff r_en=1 and empty=0; the read pointer increments modulo DEPTH.
REQ-008 The full and empty flags SHALL be sampled before the edge, so simultaneous requests resolve as follows:
- when full, a read is accepted and the write is rejected;
- when empty, a write is accepted and the read is rejected.
REQ-009 Simultaneous accepted read and write SHALL leave count unchanged.
- A lone accepted write increments count by 1.
- A lone accepted read decrements count by 1.
REQ-010 The flags full, empty, almost_full and almost_empty SHALL be decoded combinationally from the registered count, adding zero cycles of latency.
REQ-011 A rejected write SHALL assert overflow for exactly the next cycle; FIFO contents, pointers and count are unchanged.
REQ-012 A rejected read SHALL assert underflow for exactly the next cycle; pointers, count and data_out are unchanged.
REQ-013 Ordering SHALL be strict first-in, first-out across any number of pointer wrap-arounds.
REQ-014 Count SHALL never exceed DEPTH and never go below 0.

Reset
REQ-015 Asserting rst SHALL immediately, without waiting for a clock edge, clear the following to 0: both pointers, count, data_out register, overflow and underflow.
REQ-016 Consequently, during and after reset, empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0).
REQ-017 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared, but are never visible afterwards.
REQ-018 Requests presented while rst=1 SHALL be ignored and SHALL NOT raise overflow or underflow.

Configuration
REQ-019 Macro FIFO_FWFT_EN SHALL select the read mode, as below.
REQ-020 Without FIFO_FWFT_EN, data_out SHALL be registered:
- it loads the head entry on the edge where a read is accepted, so data is valid from the following cycle (1-cycle latency);
- it holds its value otherwise.
REQ-021 With FIFO_FWFT_EN, data_out SHALL be first-word-fall-through:
- it shows the head entry combinationally whenever empty=0, with 0-cycle latency;
- an accepted read advances it to the next entry after the edge;
- data_out = 0 while empty=1.
REQ-022 All flag, count, overflow and underflow behaviour SHALL be identical in both modes.

Verification
REQ-023 Fill and drain test: after reset, write 0x01..0x08 on 8 consecutive cycles (DEPTH=8).
- Expect full=1 and count=8.
- Read 8 times and expect 0x01..0x08 in order, then empty=1.
REQ-024 Overflow test: with the FIFO full, assert w_en for one cycle with data_in=0xAA.
- Expect overflow=1 for one cycle, count=8, and 0xAA never read out.
REQ-025 Underflow test: with the FIFO empty, assert r_en.
- Expect underflow=1 for one cycle, count=0, and data_out unchanged.
REQ-026 Simultaneous access test: with count=4, assert w_en and r_en together for 20 cycles.
- Expect count to stay 4 and FIFO order preserved across pointer wrap.
REQ-027 Threshold test: with AF_LEVEL=6 and AE_LEVEL=2, increment count from 0 to 8.
- Expect almost_empty=1 for counts 0-2 and almost_full=1 for counts 6-8.
REQ-028 Reset test: assert rst mid-clock with count=5.
- Expect count=0, empty=1 and data_out=0 before the next edge.
- Expect the next written word to be the next word read.
- Run in both FIFO_FWFT_EN builds and check the 1-cycle versus 0-cycle read latency.

Source files
------------

// File: rtl/sync_fifo_gen2.sv
// ---------------------------------------------------------------------------
// sync_fifo_gen2 -- single-clock FIFO with occupancy count, almost-full and
// almost-empty thresholds, and one-cycle overflow/underflow pulses.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through read data (0-cycle)
//                 undefined -> registered read data (1-cycle latency)
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo_gen2 #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         w_en,
   input  logic                         r_en,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_wr_acc;
   logic             w_rd_acc;

   // Flags decode straight from the registered count: no extra latency.
   assign full         = (r_count == C_DEPTH);
   assign empty        = (r_count == '0);
   assign almost_full  = (r_count >= C_AF);
   assign almost_empty = (r_count <= C_AE);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // Acceptance uses the pre-edge flags, so a full FIFO still takes a read
   // and an empty FIFO still takes a write in the same cycle.
   assign w_wr_acc = w_en & ~full;
   assign w_rd_acc = r_en & ~empty;

   // Storage array: written on accepted writes only.
   // NOTE: the memory has no reset; pointers and count are reset instead, so
   // stale entries can never be read and the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers, occupancy and the rejected-request pulses.
   // NOTE: all state uses non-blocking assignments so every register samples
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_en & full;
         r_underflow <= r_en & empty;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FIFO_FWFT_EN
   // Head entry shown combinationally; zero while the FIFO is empty.
   // NOTE: both branches drive data_out, so no latch is inferred.
   always_comb begin
      data_out = '0;
      if (!empty) begin
         data_out = r_mem[r_rd_ptr];
      end
   end
`else
   logic [WIDTH-1:0] r_data_out;

   // Registered read data: loads the head on an accepted read, else holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out <= '0;
      end else if (w_rd_acc) begin
         r_data_out <= r_mem[r_rd_ptr];
      end
   end

   assign data_out = r_data_out;
`endif

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_gen2 -- scoreboard bench for sync_fifo_gen2 (DEPTH=8, WIDTH=8,
// AF_LEVEL=6, AE_LEVEL=2). Build with or without FIFO_FWFT_EN; the expected
// read timing follows the same macro.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_fifo_gen2;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic             clk;
   logic             rst;
   logic             w_en;
   logic             r_en;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [3:0]       count;
   logic             overflow;
   logic             underflow;

   sync_fifo_gen2 #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .w_en         (w_en),
      .r_en         (r_en),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   logic [WIDTH-1:0] sb[$];
   logic             m_ovf;
   logic             m_unf;
   logic [WIDTH-1:0] m_dout;   // registered-mode expected data_out

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Compare every output against the reference state.
   task automatic check_state(input string ctx);
      int n;
      n = sb.size();
      check({ctx, ".count"},     32'(count),        32'(n));
      check({ctx, ".full"},      32'(full),         32'(n == DEPTH));
      check({ctx, ".empty"},     32'(empty),        32'(n == 0));
      check({ctx, ".afull"},     32'(almost_full),  32'(n >= AF));
      check({ctx, ".aempty"},    32'(almost_empty), 32'(n <= AE));
      check({ctx, ".overflow"},  32'(overflow),     32'(m_ovf));
      check({ctx, ".underflow"}, 32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
      check({ctx, ".dout"}, 32'(data_out), (n == 0) ? 32'h0 : 32'(sb[0]));
`else
      check({ctx, ".dout"}, 32'(data_out), 32'(m_dout));
`endif
   endtask

   // One clock of stimulus: drive on the falling edge, check after the rise.
   task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] d, input string ctx);
      logic             wa;
      logic             ra;
      logic [WIDTH-1:0] exp_rd;
      @(negedge clk);
      w_en    = we;
      r_en    = re;
      data_in = d;
      wa      = we && (sb.size() != DEPTH);
      ra      = re && (sb.size() != 0);
      exp_rd  = '0;
      if (ra) begin
         exp_rd = sb[0];
`ifdef FIFO_FWFT_EN
         check({ctx, ".rd_fwft"}, 32'(data_out), 32'(exp_rd));
`endif
      end
      @(posedge clk);
      #1;
      if (ra) void'(sb.pop_front());
      if (wa) sb.push_back(d);
      m_ovf = we && !wa;
      m_unf = re && !ra;
      if (ra) m_dout = exp_rd;
      check_state(ctx);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stim
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // Fill 0x01..0x08, thresholds checked at every occupancy.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i), "fill");
      check("fill.full8",  32'(full),  32'h1);
      check("fill.count8", 32'(count), 32'h8);

      // Overflow: 0xAA rejected, pulse for one cycle only.
      step(1'b1, 1'b0, 8'hAA, "ovf");
      step(1'b0, 1'b0, 8'h00, "ovf_clr");

      // Drain, expecting 0x01..0x08 in order.
      for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
      check("drain.empty", 32'(empty), 32'h1);

      // Underflow: rejected read, data_out unchanged.
      step(1'b0, 1'b1, 8'h00, "unf");
      step(1'b0, 1'b0, 8'h00, "unf_clr");

      // Simultaneous access at count=4 across several pointer wraps.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, WIDTH'(8'h10 + i), "pre4");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, WIDTH'(8'h20 + i), "simul");
      check("simul.count4", 32'(count), 32'h4);

      // Simultaneous request while full: read wins, write rejected.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i), "top");
      step(1'b1, 1'b1, 8'h55, "full_rw");
      step(1'b0, 1'b0, 8'h00, "full_rw_clr");

      // Random mixed traffic.
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom), "rand");

      // Reset mid-cycle with count=5.
      while (sb.size() > 5) step(1'b0, 1'b1, 8'h00, "to5");
      while (sb.size() < 5) step(1'b1, 1'b0, WIDTH'($urandom), "to5");
      check("pre_rst.count5", 32'(count), 32'h5);
      #2;
      rst = 1'b1;
      w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
      #1;
      sb.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      check_state("rst_async");
      check("rst_async.dout0", 32'(data_out), 32'h0);
      // Requests held through an edge while in reset are ignored.
      @(posedge clk);
      #1;
      check_state("rst_hold");
      @(negedge clk);
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;

      // Post-reset: the next word written is the next word read.
      step(1'b1, 1'b0, 8'h5A, "post_wr");
`ifdef FIFO_FWFT_EN
      check("latency.fwft0", 32'(data_out), 32'h5A);
`else
      check("latency.reg1_pre", 32'(data_out), 32'h0);
`endif
      step(1'b0, 1'b1, 8'h00, "post_rd");
`ifndef FIFO_FWFT_EN
      check("latency.reg1_post", 32'(data_out), 32'h5A);
`endif
      check("post_rd.empty", 32'(empty), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
